if_id_pipe: RTL and testbench

- IF/ID pipeline latch for the pipelined WISC processor.
- Captures the fetched instruction, PC+2 and fetch error from the fetch stage, and presents them to decode/register-file read on the next cycle.
- Supports hazard stall, branch/jump flush (bubble insertion) and sticky HALT detection, which freezes fetch.
- Sits between the fetch stage (PC register + instruction memory) and the decode stage.

---
 rtl/if_id_pipe_pkg.sv | 17 +
 rtl/if_id_pipe_if.sv | 32 +++
 rtl/if_id_pipe_reg_en_nb.sv | 22 ++
 rtl/if_id_pipe.sv | 78 +++++++
 tb/tb_if_id_pipe.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_pipe_pkg.sv
// Shared ISA definitions for the IF/ID pipeline latch: datapath width,
// opcode constants, the bubble encoding and the latch control-bit bundle.
package if_id_pipe_pkg;

    localparam int          WIDTH     = 16;
    localparam logic [4:0]  HALT_OPC  = 5'b00000;
    localparam logic [4:0]  NOP_OPC   = 5'b00001;
    localparam logic [15:0] NOP_INSTR = {NOP_OPC, 11'b0};

    // Control bits carried alongside the instruction through IF/ID.
    typedef struct packed {
        logic valid;
        logic err;
        logic halt;
    } ctrl_t;

endpackage

// File: rtl/if_id_pipe_if.sv
// Fetch-to-decode bus of the IF/ID latch.
// master: the fetch stage and hazard unit. It drives if_* and stall/flush,
//         and it observes id_* and fetch_halt.
// slave : the latch. It drives id_* and fetch_halt.
// There is no handshake. stall holds the latch and flush squashes it, both
// sampled on the rising clock edge. if_valid marks a real fetch, and id_valid
// marks a real, non-squashed instruction in ID.
interface if_id_pipe_if #(
    parameter int WIDTH = if_id_pipe_pkg::WIDTH
);
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_pc2;
    logic             if_valid;
    logic             if_err;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] id_instr;
    logic [WIDTH-1:0] id_pc2;
    logic             id_valid;
    logic             id_err;
    logic             fetch_halt;

    modport master (
        output if_instr, if_pc2, if_valid, if_err, stall, flush,
        input  id_instr, id_pc2, id_valid, id_err, fetch_halt
    );

    modport slave (
        input  if_instr, if_pc2, if_valid, if_err, stall, flush,
        output id_instr, id_pc2, id_valid, id_err, fetch_halt
    );
endinterface

// File: rtl/if_id_pipe_reg_en_nb.sv
// Generic enable register with asynchronous active-low reset to RESET_VAL.
module reg_en_nb #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled. Otherwise hold the current value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline latch. It captures the fetched instruction, PC+2 and the
// fetch error, and presents them to decode one cycle later.
// Priority per edge: flush > stall > halted (bubble) > normal load.
// fetch_halt is sticky once a valid HALT is loaded. Only flush or reset
// clears it.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int               WIDTH     = if_id_pipe_pkg::WIDTH,
    parameter logic [WIDTH-1:0] NOP_INSTR = if_id_pipe_pkg::NOP_INSTR,
    parameter logic [4:0]       HALT_OPC  = if_id_pipe_pkg::HALT_OPC
) (
    input logic         clk,
    input logic         rst_n,
    if_id_pipe_if.slave bus
);

    logic [WIDTH-1:0] instr_d, instr_q;
    logic [WIDTH-1:0] pc2_d, pc2_q;
    ctrl_t            ctrl_d, ctrl_q;
    logic             load_en;

    // Stall freezes every register, fetch_halt included. Flush overrides stall.
    assign load_en = bus.flush | ~bus.stall;

    // Select the next latch contents by priority.
    always_comb begin
        instr_d      = NOP_INSTR;
        pc2_d        = '0;
        ctrl_d.valid = 1'b0;
        ctrl_d.err   = 1'b0;
        ctrl_d.halt  = 1'b0;
        if (bus.flush) begin
            // Squash: bubble, and any halt from a mispredicted path is cancelled.
            ctrl_d.halt = 1'b0;
        end else if (ctrl_q.halt) begin
            // Halted: keep inserting bubbles so nothing past HALT enters decode.
            ctrl_d.halt = 1'b1;
        end else begin
            instr_d      = bus.if_valid ? bus.if_instr : NOP_INSTR;
            pc2_d        = bus.if_pc2;
            ctrl_d.valid = bus.if_valid;
            ctrl_d.err   = bus.if_valid & bus.if_err;
            ctrl_d.halt  = bus.if_valid && (bus.if_instr[WIDTH-1 -: 5] == HALT_OPC);
        end
    end

    reg_en_nb #(.WIDTH(WIDTH), .RESET_VAL(NOP_INSTR)) u_instr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .d     (instr_d),
        .q     (instr_q)
    );

    reg_en_nb #(.WIDTH(WIDTH), .RESET_VAL('0)) u_pc2_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .d     (pc2_d),
        .q     (pc2_q)
    );

    reg_en_nb #(.WIDTH(3), .RESET_VAL(3'b000)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_en),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    assign bus.id_instr   = instr_q;
    assign bus.id_pc2     = pc2_q;
    assign bus.id_valid   = ctrl_q.valid;
    assign bus.id_err     = ctrl_q.err;
    assign bus.fetch_halt = ctrl_q.halt;

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for the IF/ID latch: directed scenarios with fixed expected values,
// then randomized traffic checked against an edge-level reference model.
module tb_if_id_pipe;

    localparam int          W   = 16;
    localparam logic [15:0] NOP = 16'h0800;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    if_id_pipe_if #(.WIDTH(W)) bus ();

    if_id_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_instr;
    logic [W-1:0] m_pc2;
    logic         m_valid;
    logic         m_err;
    logic         m_halt;

    // Expected output bundle: {instr, pc2, valid, err, halt}.
    logic [2*W+2:0] exp_q[$];

    task automatic model_reset();
        m_instr = NOP; m_pc2 = '0; m_valid = 0; m_err = 0; m_halt = 0;
    endtask

    // Apply one rising edge worth of behaviour using the current inputs.
    task automatic model_edge();
        if (bus.flush) begin
            m_instr = NOP; m_pc2 = '0; m_valid = 0; m_err = 0; m_halt = 0;
        end else if (bus.stall) begin
            // hold everything
        end else if (m_halt) begin
            m_instr = NOP; m_pc2 = '0; m_valid = 0; m_err = 0;
        end else begin
            m_valid = bus.if_valid;
            m_instr = bus.if_valid ? bus.if_instr : NOP;
            m_pc2   = bus.if_pc2;
            m_err   = bus.if_valid && bus.if_err;
            if (bus.if_valid && bus.if_instr[15:11] == 5'b00000) m_halt = 1;
        end
    endtask

    function automatic logic [2*W+2:0] observed();
        return {bus.id_instr, bus.id_pc2, bus.id_valid, bus.id_err, bus.fetch_halt};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [W-1:0] instr, input logic [W-1:0] pc2,
                         input logic valid, input logic err,
                         input logic stl, input logic fl);
        bus.if_instr = instr; bus.if_pc2 = pc2; bus.if_valid = valid;
        bus.if_err = err; bus.stall = stl; bus.flush = fl;
    endtask

    // Advance the model and the DUT by one edge, then settle past the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(16'h4123, 16'h0010, 1, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.id_instr !== 16'h4123 || bus.id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_preload: got instr=%h valid=%b want 4123/1", bus.id_instr, bus.id_valid);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.id_instr !== 16'h0800 || bus.id_pc2 !== 16'h0000 || bus.id_valid !== 1'b0 ||
            bus.id_err !== 1'b0 || bus.fetch_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", observed(), {NOP, 16'h0, 3'b000});
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_normal();
        drive(16'hC105, 16'h0002, 1, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.id_instr !== 16'hC105 || bus.id_pc2 !== 16'h0002 || bus.id_valid !== 1'b1 ||
            bus.id_err !== 1'b0 || bus.fetch_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_flow: got %h want %h", observed(), {16'hC105, 16'h0002, 3'b100});
        end
        drive(16'h1234, 16'h0004, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.id_instr !== NOP || bus.id_pc2 !== 16'h0004 || bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_invalid: got %h want %h", observed(), {NOP, 16'h0004, 3'b000});
        end
    endtask

    task automatic test_stall();
        drive(16'hC105, 16'h0002, 1, 0, 0, 0);
        tick();
        drive(16'hD20A, 16'h0004, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.id_instr !== 16'hC105 || bus.id_pc2 !== 16'h0002 || bus.id_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got instr=%h pc2=%h want C105/0002", i, bus.id_instr, bus.id_pc2);
            end
        end
        bus.stall = 1'b0;
        tick();
        n_checks++;
        if (bus.id_instr !== 16'hD20A || bus.id_pc2 !== 16'h0004) begin
            n_fail++;
            $display("FAIL stall_release: got instr=%h pc2=%h want D20A/0004", bus.id_instr, bus.id_pc2);
        end
    endtask

    task automatic test_flush_vs_stall();
        drive(16'hC105, 16'h0002, 1, 1, 0, 0);
        tick();
        drive(16'h5555, 16'h0006, 1, 0, 1, 1);
        tick();
        n_checks++;
        if (bus.id_instr !== 16'h0800 || bus.id_valid !== 1'b0 || bus.id_pc2 !== 16'h0000 ||
            bus.id_err !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_vs_stall: got %h want %h", observed(), {NOP, 16'h0, 3'b000});
        end
    endtask

    task automatic test_error();
        drive(16'h1234, 16'h0008, 1, 1, 0, 0);
        tick();
        n_checks++;
        if (bus.id_err !== 1'b1 || bus.id_valid !== 1'b1 || bus.id_instr !== 16'h1234) begin
            n_fail++;
            $display("FAIL err_valid: got err=%b valid=%b want 1/1", bus.id_err, bus.id_valid);
        end
        drive(16'h1234, 16'h000A, 0, 1, 0, 0);
        tick();
        n_checks++;
        if (bus.id_err !== 1'b0 || bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_invalid: got err=%b valid=%b want 0/0", bus.id_err, bus.id_valid);
        end
    endtask

    task automatic test_halt();
        drive(16'h0000, 16'h0020, 1, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.id_instr !== 16'h0000 || bus.id_valid !== 1'b1 || bus.fetch_halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_latch: got %h want %h", observed(), {16'h0000, 16'h0020, 3'b101});
        end
        drive(16'h4444, 16'h0022, 1, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.id_instr !== 16'h0800 || bus.id_valid !== 1'b0 || bus.fetch_halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_bubble: got %h want %h", observed(), {NOP, 16'h0, 3'b001});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (bus.fetch_halt !== 1'b1 || bus.id_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_sticky[%0d]: got halt=%b valid=%b want 1/0", i, bus.fetch_halt, bus.id_valid);
            end
        end
        bus.flush = 1'b1;
        tick();
        n_checks++;
        if (bus.fetch_halt !== 1'b0 || bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_flush: got halt=%b valid=%b want 0/0", bus.fetch_halt, bus.id_valid);
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_halt_squash();
        drive(16'h0000, 16'h0030, 1, 0, 0, 0);
        tick();
        drive(16'h7777, 16'h0032, 1, 0, 0, 1);
        tick();
        n_checks++;
        if (bus.fetch_halt !== 1'b0 || bus.id_instr !== 16'h0800 || bus.id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_flush: got %h want %h", observed(), {NOP, 16'h0, 3'b000});
        end
        drive(16'h4444, 16'h0034, 1, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.id_instr !== 16'h4444 || bus.id_valid !== 1'b1 || bus.fetch_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_resume: got %h want %h", observed(), {16'h4444, 16'h0034, 3'b100});
        end
    endtask

    task automatic test_random();
        logic [2*W+2:0] exp;
        logic [2*W+2:0] obs;
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] instr;
            instr = W'($urandom);
            if ($urandom_range(0, 9) == 0) instr[15:11] = 5'b00000;
            drive(instr, W'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
            model_edge();
            exp_q.push_back({m_instr, m_pc2, m_valid, m_err, m_halt});
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            obs = observed();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive('0, '0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (observed() !== {NOP, 16'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_initial: got %h want %h", observed(), {NOP, 16'h0, 3'b000});
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        test_reset();
        test_normal();
        test_stall();
        test_flush_vs_stall();
        test_error();
        test_halt();
        test_halt_squash();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
